// File: rtl/pxs_sprite_motion_ctrl_if.sv
// Pixel-stream input, user controls and sprite-state outputs of the Pxs motion sequencer.
// The slave modport is the sequencer; the master modport is whoever drives the stream and reads the sprite state.
interface pxs_sprite_motion_ctrl_if;
  logic [25:0] RGBStr_i;
  logic        inc_vel;
  logic        dec_vel;
  logic        pause;
  logic [9:0]  x_sprite;
  logic [9:0]  y_sprite;
  logic [1:0]  index_img;
  logic [3:0]  speed;
  logic        bounce;
  logic        busy;

  modport master (
    output RGBStr_i, inc_vel, dec_vel, pause,
    input  x_sprite, y_sprite, index_img, speed, bounce, busy
  );

  modport slave (
    input  RGBStr_i, inc_vel, dec_vel, pause,
    output x_sprite, y_sprite, index_img, speed, bounce, busy
  );
endinterface

// File: rtl/pxs_sprite_motion_ctrl.sv
// Per-frame bouncing-sprite sequencer: at end of visible frame it bounces, moves and animates the sprite.
// state  | meaning
// IDLE   | waiting for end of visible frame (pause sampled here)
// CHECK  | flip dx/dy at the borders, remember whether anything flipped
// MOVE   | step position by speed, bounce pulse if a flip was remembered
// ANIM   | apply speed change, advance frame counter / image index
module pxs_sprite_motion_ctrl #(
  parameter int VISIBLECOLS   = 640,
  parameter int VISIBLEROWS   = 480,
  parameter int WIDTH_SPRITE  = 16,
  parameter int HEIGHT_SPRITE = 16,
  parameter int BORDER        = 0,
  parameter int X_INIT        = (VISIBLECOLS - WIDTH_SPRITE) / 2,
  parameter int Y_INIT        = (VISIBLEROWS - HEIGHT_SPRITE) / 2,
  parameter int INIT_SPEED    = 1,
  parameter int MAX_SPEED     = 15,
  parameter int ANIM_PERIOD   = 11
) (
  input  logic                      px_clk,
  input  logic                      rst_n,
  pxs_sprite_motion_ctrl_if.slave   sif
);

  localparam int XMAX = VISIBLECOLS - WIDTH_SPRITE - BORDER;
  localparam int YMAX = VISIBLEROWS - HEIGHT_SPRITE - BORDER;
  localparam int FCW  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_ANIM} state_t;

  state_t         state_q, state_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic           dx_q, dx_d, dy_q, dy_d;
  logic           flip_q, flip_d;
  logic [3:0]     speed_q, speed_d;
  logic [1:0]     index_q, index_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  // Pxs stream: XC in bits [19:10], YC in bits [9:0]
  logic [9:0]  xc, yc;
  logic        endframe;
  logic [10:0] x_ext, y_ext, spd_ext;

  assign xc       = sif.RGBStr_i[19:10];
  assign yc       = sif.RGBStr_i[9:0];
  assign endframe = (xc == 10'(VISIBLECOLS - 1)) && (yc == 10'(VISIBLEROWS - 1));
  assign x_ext    = {1'b0, x_q};
  assign y_ext    = {1'b0, y_q};
  assign spd_ext  = {7'd0, speed_q};

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= 10'(X_INIT);
      y_q         <= 10'(Y_INIT);
      dx_q        <= 1'b0;
      dy_q        <= 1'b0;
      flip_q      <= 1'b0;
      speed_q     <= 4'(INIT_SPEED);
      index_q     <= 2'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      flip_q      <= flip_d;
      speed_q     <= speed_d;
      index_q     <= index_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    flip_d      = flip_q;
    speed_d     = speed_q;
    index_d     = index_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (endframe && !sif.pause) state_d = S_CHECK;
      end
      S_CHECK: begin
        // 11-bit compares so x+speed past 1023 cannot wrap into range
        if (!dx_q && (x_ext + spd_ext > 11'(XMAX)))        dx_d = 1'b1;
        else if (dx_q && (x_ext < 11'(BORDER) + spd_ext))  dx_d = 1'b0;
        if (!dy_q && (y_ext + spd_ext > 11'(YMAX)))        dy_d = 1'b1;
        else if (dy_q && (y_ext < 11'(BORDER) + spd_ext))  dy_d = 1'b0;
        flip_d  = (dx_d != dx_q) || (dy_d != dy_q);
        state_d = S_MOVE;
      end
      S_MOVE: begin
        x_d     = dx_q ? x_q - {6'd0, speed_q} : x_q + {6'd0, speed_q};
        y_d     = dy_q ? y_q - {6'd0, speed_q} : y_q + {6'd0, speed_q};
        state_d = S_ANIM;
      end
      S_ANIM: begin
        if (sif.inc_vel && !sif.dec_vel && (speed_q < 4'(MAX_SPEED)))
          speed_d = speed_q + 4'd1;
        else if (sif.dec_vel && !sif.inc_vel && (speed_q != 4'd0))
          speed_d = speed_q - 4'd1;
        if (frame_cnt_q == FCW'(ANIM_PERIOD - 1)) begin
          frame_cnt_d = '0;
          index_d     = dy_q ? index_q + 2'd1 : index_q - 2'd1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sif.x_sprite  = x_q;
  assign sif.y_sprite  = y_q;
  assign sif.index_img = index_q;
  assign sif.speed     = speed_q;
  assign sif.bounce    = (state_q == S_MOVE) && flip_q;
  assign sif.busy      = (state_q != S_IDLE);

endmodule
